// File: rtl/tx_bus_arb.sv
// tx_bus_arb: two-requester round-robin arbiter feeding one byte-wide bus transmitter
//
// Ports:
//   sys_clk, sys_rst          clock and asynchronous active-high reset
//   a_req / b_req             level request for one frame
//   a_gnt / b_gnt             registered grant, held for the whole frame
//   a_data, b_data            requester bytes
//   a_data_flag, b_data_flag  one-cycle strobe, byte valid
//   a_last, b_last            final byte of frame, sampled with the strobe
//   a_send_finish, b_send_finish  one-cycle pulse, byte has left the bus
//   bus_data, bus_data_flag   byte and strobe to the transmitter
//   bus_send_finish           transmitter has sent the byte
//   busy                      not IDLE
//   proto_err                 sticky protocol-error flag
//   timeout_err               one-cycle pulse on per-byte watchdog expiry
//
// Optional feature: define TX_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog;
// without it the block waits indefinitely and timeout_err is tied low.
module tx_bus_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       a_req,
    output logic       a_gnt,
    input  logic [7:0] a_data,
    input  logic       a_data_flag,
    input  logic       a_last,
    output logic       a_send_finish,
    input  logic       b_req,
    output logic       b_gnt,
    input  logic [7:0] b_data,
    input  logic       b_data_flag,
    input  logic       b_last,
    output logic       b_send_finish,
    output logic [7:0] bus_data,
    output logic       bus_data_flag,
    input  logic       bus_send_finish,
    output logic       busy,
    output logic       proto_err,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, WAIT_BYTE, WAIT_FIN} state_t;

    state_t     state;
    logic       last_b;
    logic       last_lat;
    logic       g_flag;
    logic       bad_flag;
    logic [7:0] g_data;
    logic       g_last;
    logic       tmo;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("TIMEOUT_CYCLES out of range");
    end

    assign g_flag   = (a_gnt & a_data_flag) | (b_gnt & b_data_flag);
    assign bad_flag = (~a_gnt & a_data_flag) | (~b_gnt & b_data_flag);
    assign g_data   = a_gnt ? a_data : b_data;
    assign g_last   = a_gnt ? a_last : b_last;
    assign busy     = state != IDLE;

`ifdef TX_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic        adv;
    // adv marks a state change, so the counter restarts on every entry to a wait state
    assign adv = (state == IDLE && (a_req || b_req)) || (state == WAIT_BYTE && g_flag) ||
                 (state == WAIT_FIN && bus_send_finish);
    assign tmo = state != IDLE && cnt == 16'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= (adv || state == IDLE) ? 16'd0 : cnt + 16'd1;
            timeout_err <= tmo;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            a_gnt         <= 1'b0;
            b_gnt         <= 1'b0;
            bus_data      <= 8'h00;
            bus_data_flag <= 1'b0;
            a_send_finish <= 1'b0;
            b_send_finish <= 1'b0;
            proto_err     <= 1'b0;
            last_b        <= 1'b1;
            last_lat      <= 1'b0;
        end else begin
            bus_data_flag <= 1'b0;
            a_send_finish <= 1'b0;
            b_send_finish <= 1'b0;
            if (bad_flag || (g_flag && state == WAIT_FIN) || (bus_send_finish && state != WAIT_FIN))
                proto_err <= 1'b1;
            if (tmo) begin
                state  <= IDLE;
                a_gnt  <= 1'b0;
                b_gnt  <= 1'b0;
                last_b <= b_gnt;
            end else begin
                case (state)
                    IDLE: if (a_req || b_req) begin
                        // on a tie the requester not served last wins
                        a_gnt <= a_req & (~b_req | last_b);
                        b_gnt <= b_req & (~a_req | ~last_b);
                        state <= WAIT_BYTE;
                    end
                    WAIT_BYTE: if (g_flag) begin
                        bus_data      <= g_data;
                        bus_data_flag <= 1'b1;
                        last_lat      <= g_last;
                        state         <= WAIT_FIN;
                    end
                    WAIT_FIN: if (bus_send_finish) begin
                        a_send_finish <= a_gnt;
                        b_send_finish <= b_gnt;
                        if (last_lat) begin
                            a_gnt  <= 1'b0;
                            b_gnt  <= 1'b0;
                            last_b <= b_gnt;
                            state  <= IDLE;
                        end else begin
                            state <= WAIT_BYTE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
